// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
// Round-robin arbiter that shares one WIDTH-bit storage register among
// N_REQ requesters. A winning requester holds the grant for one cycle and
// its data is captured into the shared register on the closing edge. The
// cycle after that reports completion, and a new winner may be chosen on
// that same edge.
//
// Ports:
//   i_clk      - system clock, all state changes on the rising edge
//   i_rst      - synchronous active-high reset
//   i_req      - per-requester level-sensitive write request
//   i_wdata    - flattened write data, requester i at [i*WIDTH +: WIDTH]
//   o_gnt      - registered one-hot grant, zero when nobody is granted
//   o_q        - shared register contents
//   o_q_valid  - high once any write has completed since reset
//   o_owner    - index of the requester that performed the last write
//   o_wr_done  - one-cycle pulse in the cycle after o_q is updated
//   o_busy     - high whenever the sequencer is not idle
module reg_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*WIDTH-1:0]   i_wdata,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [WIDTH-1:0]         o_q,
  output logic                     o_q_valid,
  output logic [$clog2(N_REQ)-1:0] o_owner,
  output logic                     o_wr_done,
  output logic                     o_busy
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [N_REQ-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_k;
  logic [IDX_W-1:0]   r_rrPtr;
  logic [WIDTH-1:0]   r_q;
  logic               r_qValid;
  logic [IDX_W-1:0]   r_owner;
  logic               w_found;
  logic [IDX_W-1:0]   w_winner;

  // Round-robin search: start at r_rrPtr and wrap, first requester seen wins.
  // The search runs every cycle but only matters in IDLE and WRITE.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(r_rrPtr) + i) % N_REQ;
      if (!w_found && i_req[idx]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(idx);
      end
    end
  end

  // Next-state logic. GRANT and WRITE each last exactly one cycle; WRITE may
  // chain straight into a new GRANT so back-to-back writes take two cycles.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_found) w_nextState = GRANT;
      GRANT:   w_nextState = WRITE;
      WRITE:   w_nextState = w_found ? GRANT : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State, grant and shared register. The write on leaving GRANT is
  // unconditional: once granted, dropping the request cannot cancel it.
  // r_k remembers the winner so the capture uses the granted slice even if
  // requests change during the grant cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_k      <= '0;
      r_rrPtr  <= '0;
      r_q      <= '0;
      r_qValid <= 1'b0;
      r_owner  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState == GRANT) begin
        r_gnt <= N_REQ'(1) << w_winner;
        r_k   <= w_winner;
      end else begin
        r_gnt <= '0;
      end
      if (r_state == GRANT) begin
        r_q      <= i_wdata[int'(r_k)*WIDTH +: WIDTH];
        r_owner  <= r_k;
        r_qValid <= 1'b1;
        r_rrPtr  <= (r_k == IDX_W'(N_REQ-1)) ? '0 : r_k + IDX_W'(1);
      end
    end
  end

  assign o_gnt     = r_gnt;
  assign o_q       = r_q;
  assign o_q_valid = r_qValid;
  assign o_owner   = r_owner;
  assign o_wr_done = (r_state == WRITE);
  assign o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter
// Randomised bench for reg_share_arbiter. A transaction-level model decides,
// edge by edge, which requester should win from the request pattern and the
// round-robin pointer, and pushes the expected grant and write into
// scoreboard queues. A monitor on the falling edge pops and compares them
// when the DUT shows a grant or a completed write, and also checks the
// steady-state outputs every cycle.
module tb_reg_share_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int N_CYC = 1200;

  logic                     clk;
  logic                     rst;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*WIDTH-1:0]   wdata;
  logic [N_REQ-1:0]         gnt;
  logic [WIDTH-1:0]         q;
  logic                     qValid;
  logic [IDX_W-1:0]         owner;
  logic                     wrDone;
  logic                     busy;

  typedef struct {
    int data;
    int owner;
  } wr_t;

  int  gntQ[$];
  wr_t wrQ[$];

  int  nChecks = 0;
  int  nErrors = 0;
  int  cyc = 0;
  int  lastArb = -10;
  int  rrPtr = 0;
  int  pendWinner = 0;
  int  pendData = 0;
  int  expQ = 0;
  int  expOwner = 0;
  bit  expValid = 0;
  bit  expWrDone = 0;
  bit  expGntOn = 0;
  bit  expBusy = 0;
  bit  started = 0;
  bit  done = 0;

  reg_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_wdata   (wdata),
    .o_gnt     (gnt),
    .o_q       (q),
    .o_q_valid (qValid),
    .o_owner   (owner),
    .o_wr_done (wrDone),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs the DUT sees.
  // The arbiter is free to pick a winner unless it granted on the previous
  // edge; the granted data lands in the register one edge after the pick.
  task automatic modelEdge();
    cyc++;
    started = 1;
    if (rst) begin
      lastArb   = -10;
      rrPtr     = 0;
      expQ      = 0;
      expOwner  = 0;
      expValid  = 0;
      expWrDone = 0;
      expGntOn  = 0;
      expBusy   = 0;
      gntQ.delete();
      wrQ.delete();
      return;
    end
    expWrDone = 0;
    if (lastArb == cyc - 1) begin
      expQ      = pendData;
      expOwner  = pendWinner;
      expValid  = 1;
      expWrDone = 1;
      rrPtr     = (pendWinner + 1) % N_REQ;
    end else if (req != '0) begin
      for (int i = 0; i < N_REQ; i++) begin
        int idx;
        idx = (rrPtr + i) % N_REQ;
        if (req[idx]) begin
          wr_t w;
          pendWinner = idx;
          pendData   = int'(wdata[idx*WIDTH +: WIDTH]);
          lastArb    = cyc;
          gntQ.push_back(1 << idx);
          w.data  = pendData;
          w.owner = idx;
          wrQ.push_back(w);
          break;
        end
      end
    end
    expGntOn = (lastArb == cyc);
    expBusy  = (lastArb == cyc) || (lastArb == cyc - 1);
  endtask

  // Drives the inputs for the next edge. Phases: random, full contention,
  // sparse, then idle drain. Random resets are sprinkled in, plus forced
  // resets during a grant. Data of a granted requester is held stable.
  task automatic applyStimulus(input int t);
    logic [N_REQ*WIDTH-1:0] nextData;
    logic [WIDTH-1:0]       held;
    held     = wdata[pendWinner*WIDTH +: WIDTH];
    nextData = {$urandom, $urandom};
    if (lastArb == cyc)
      nextData[pendWinner*WIDTH +: WIDTH] = held;
    if (t < 3) begin
      rst = 1'b1;
      req = '1;
    end else if (t < N_CYC - 50) begin
      rst = ($urandom_range(0, 59) == 0) || ((t % 97 == 0) && (lastArb == cyc));
      if (t < 400)
        req = N_REQ'($urandom);
      else if (t < 500)
        req = '1;
      else if (t < 800) begin
        for (int i = 0; i < N_REQ; i++) req[i] = ($urandom_range(0, 7) == 0);
      end else if (t % 4 == 0)
        req = N_REQ'($urandom);
    end else begin
      rst = 1'b0;
      req = '0;
    end
    wdata = nextData;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    for (int t = 0; t < N_CYC; t++) begin
      @(posedge clk);
      modelEdge();
      #1;
      applyStimulus(t);
    end
    @(negedge clk);
    done = 1;
    checkOutput("grant_queue_drained", gntQ.size(), 0);
    checkOutput("write_queue_drained", wrQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  // Monitor: scoreboard pops on grant and write completion, plus per-cycle
  // checks of the register outputs against the model.
  always @(negedge clk) begin
    if (started && !done) begin
      checkOutput("gnt_onehot", int'($countones(gnt) <= 1), 1);
      checkOutput("gnt_present", int'(gnt != '0), int'(expGntOn));
      if (gnt != '0) begin
        if (gntQ.size() == 0)
          checkOutput("gnt_unexpected", int'(gnt), 0);
        else
          checkOutput("gnt_value", int'(gnt), gntQ.pop_front());
      end
      checkOutput("wr_done", int'(wrDone), int'(expWrDone));
      if (wrDone) begin
        if (wrQ.size() == 0)
          checkOutput("wr_unexpected", 1, 0);
        else begin
          wr_t w;
          w = wrQ.pop_front();
          checkOutput("wr_q", int'(q), w.data);
          checkOutput("wr_owner", int'(owner), w.owner);
        end
      end
      checkOutput("q", int'(q), expQ);
      checkOutput("q_valid", int'(qValid), int'(expValid));
      checkOutput("owner", int'(owner), expOwner);
      checkOutput("busy", int'(busy), int'(expBusy));
    end
  end

endmodule
